uart_bridge: RTL and testbench
==============================

# uart_bridge

Sequencer between the data-side memory controller and the board's serial-port chip. It turns one-cycle read, write and status commands into the chip's `rdn`/`wrn` strobe protocol on the shared 8-bit data bus, and waits on `data_ready`/`tbre`/`tsre` as the protocol requires. It returns a 16-bit result with a one-cycle `done` pulse, so the MEM stage can hold the pipeline while `busy` is high.

## Interface
- `RD_PULSE`, default 2: cycles `rdn` is held low per read (≥1).
- `WR_PULSE`, default 2: cycles `wrn` is held low per write (≥1).
- `CLK` — input, 1: the only clock; all logic on its rising edge.
- `RST` — input, 1: asynchronous, active-high reset.
- `cmd_read` — input, 1: request one received byte.
- `cmd_write` — input, 1: request transmission of `wdata`.
- `cmd_status` — input, 1: request the status word.
- `wdata` — input, 8: byte to transmit; sampled at accept.
- `rdata` — output, 16: result, valid while `done`=1 and held until the next accept.
- `busy` — output, 1: a command is in progress.
- `done` — output, 1: one-cycle completion pulse.
- `data_ready` — input, 1: the chip has a received byte.
- `tbre` — input, 1: the chip's transmit buffer is empty.
- `tsre` — input, 1: the chip's transmit shift register is empty.
- `rdn` — output, 1: active-low read strobe.
- `wrn` — output, 1: active-low write strobe.
- `uart_data` — inout, 8: shared bus; driven only in write states, high-Z otherwise.

## Operation
- States: IDLE, RD_WAIT, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, WR_WAIT_TBRE, WR_WAIT_TSRE, FINISH.
- Accept:
  - A command is accepted only in IDLE; commands in other states are ignored.
  - Priority when several are high: write > read > status.
  - Accept latches `wdata` and raises `busy` the next cycle.
- Status:
  - IDLE → FINISH.
  - `rdata` = {14'b0, `data_ready`, `tbre` & `tsre`}, sampled at accept.
- Read:
  - IDLE → RD_WAIT.
  - RD_WAIT holds until `data_ready`=1, then → RD_STROBE.
  - RD_STROBE drives `rdn`=0 for `RD_PULSE` cycles.
  - On the last low cycle, `rdata` = {8'b0, `uart_data`}.
  - Then → FINISH with `rdn`=1.
- Write:
  - IDLE → WR_SETUP: drive bus, `wrn`=1, 1 cycle.
  - WR_STROBE: drive bus, `wrn`=0, `WR_PULSE` cycles.
  - WR_HOLD: drive bus, `wrn`=1, 1 cycle.
  - WR_WAIT_TBRE: bus high-Z, wait until `tbre`=1.
  - WR_WAIT_TSRE: wait until `tsre`=1.
  - Then → FINISH with `rdata`=0.
- FINISH: `done`=1, `busy`=0, → IDLE.
  - A command presented during FINISH is ignored.
  - The requester drops its command on `done`.
- The strobe counter is 3 bits wide. `RD_PULSE`/`WR_PULSE` above 7 are illegal.
- Never drive the bus and assert `rdn` in the same cycle.
- `rdn` and `wrn` are never low together.

## Timing
- Reset values: `rdn`=1, `wrn`=1, `uart_data`=Z, `busy`=0, `done`=0, `rdata`=0, state IDLE.
- All outputs are registered.
- Status latency: accept at cycle 0 → `done` at cycle 1.
- Read latency: accept at cycle 0, `data_ready` already high → `rdn` low cycles 2..1+`RD_PULSE` → `done` at cycle 2+`RD_PULSE`.
- Write latency: accept at cycle 0, `tbre`/`tsre` already high → `wrn` low cycles 2..1+`WR_PULSE` → `done` at cycle 5+`WR_PULSE`.
- No timeout: RD_WAIT and the write wait states stall indefinitely.
- `RST` mid-operation:
  - Releases the bus and strobes immediately (asynchronous).
  - No `done` is produced for the aborted command.
- `data_ready` dropping during RD_STROBE does not abort the strobe.

## Configuration
- `UART_BRIDGE_SYNC_EN`
  - Defined: `data_ready`, `tbre`, `tsre` each pass through a 2-flop synchronizer (reset to 0) before use.
    - Every wait decision and the status word see values 2 cycles late.
    - Status latency is unchanged; the status word reflects the synchronized values.
  - Undefined: the raw inputs are used directly and the latencies above hold exactly.

## Test plan
- Reset and status:
  - Stimulus: after reset, `cmd_status` with `data_ready`=1, `tbre`=1, `tsre`=0.
  - Response: outputs at reset values; `done` at cycle 1 with `rdata`=16'h0002.
- Read:
  - Stimulus: `cmd_read` with `data_ready`=0 for 5 cycles, then 1; chip drives 8'hA5.
  - Response: `rdn` low exactly 2 cycles (default `RD_PULSE`); `rdata`=16'h00A5; `done` single-cycle.
- Write:
  - Stimulus: `cmd_write`, `wdata`=8'h3C; `tbre` rises 10 cycles after `wrn` goes high, `tsre` 4 cycles later.
  - Response: bus=8'h3C throughout WR_SETUP..WR_HOLD; `wrn` low 2 cycles; `done` one cycle after `tsre` is seen high; `rdata`=0.
- Priority and busy:
  - Stimulus: `cmd_write`, `cmd_read`, `cmd_status` all high at once; then `cmd_read` pulsed mid-write.
  - Response: the write is executed; the mid-write read is ignored; `rdn` never low.
- Reset abort:
  - Stimulus: `RST` during WR_STROBE.
  - Response: `wrn`=1 and bus Z in the same cycle; no `done`; next `cmd_status` completes normally.
- `UART_BRIDGE_SYNC_EN` defined:
  - Stimulus: repeat the read test.
  - Response: `rdn` falls 2 cycles later than without the macro.

Source files
------------

// File: rtl/uart_bridge.sv
// Sequencer turning one-cycle read/write/status commands into the serial chip's rdn/wrn strobe protocol.
// Optional macro UART_BRIDGE_SYNC_EN adds 2-flop synchronizers on data_ready, tbre and tsre.
module uart_bridge #(
    parameter int RD_PULSE = 2,
    parameter int WR_PULSE = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_read,
    input  logic        cmd_write,
    input  logic        cmd_status,
    input  logic [7:0]  wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic        rdn,
    output logic        wrn,
    inout  wire  [7:0]  uart_data
);

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        RD_WAIT      = 4'd1,
        RD_STROBE    = 4'd2,
        WR_SETUP     = 4'd3,
        WR_STROBE    = 4'd4,
        WR_HOLD      = 4'd5,
        WR_WAIT_TBRE = 4'd6,
        WR_WAIT_TSRE = 4'd7,
        FINISH       = 4'd8
    } state_t;

    localparam logic [2:0] RD_LAST = 3'(RD_PULSE - 1);
    localparam logic [2:0] WR_LAST = 3'(WR_PULSE - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rdn_q, rdn_d;
    logic        wrn_q, wrn_d;
    logic        drive_q, drive_d;
    logic        dr_s, tbre_s, tsre_s;

`ifdef UART_BRIDGE_SYNC_EN
    logic [2:0] sync1_q, sync2_q;

    // Two-flop synchronizers for the chip's status lines.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {data_ready, tbre, tsre};
            sync2_q <= sync1_q;
        end
    end

    assign {dr_s, tbre_s, tsre_s} = sync2_q;
`else
    assign {dr_s, tbre_s, tsre_s} = {data_ready, tbre, tsre};
`endif

    // Next-state, strobe counter and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (cmd_write) begin
                    state_d = WR_SETUP;
                    wdata_d = wdata;
                end else if (cmd_read) begin
                    state_d = RD_WAIT;
                    wdata_d = wdata;
                end else if (cmd_status) begin
                    state_d = FINISH;
                    wdata_d = wdata;
                    rdata_d = {14'h0000, dr_s, tbre_s & tsre_s};
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (dr_s) begin
                    state_d = RD_STROBE;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_STROBE: begin
                // The chip drives the bus while rdn is low; take the byte at the end of the last low cycle.
                if (cnt_q == RD_LAST) begin
                    state_d = FINISH;
                    rdata_d = {8'h00, uart_data};
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_STROBE;
                cnt_d   = 3'd0;
            end
            WR_STROBE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WR_HOLD: begin
                state_d = WR_WAIT_TBRE;
            end
            WR_WAIT_TBRE: begin
                if (tbre_s) begin
                    state_d = WR_WAIT_TSRE;
                end else begin
                    state_d = WR_WAIT_TBRE;
                end
            end
            WR_WAIT_TSRE: begin
                if (tsre_s) begin
                    state_d = FINISH;
                    rdata_d = 16'h0000;
                end else begin
                    state_d = WR_WAIT_TSRE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        rdn_d   = 1'b1;
        wrn_d   = 1'b1;
        drive_d = 1'b0;
        case (state_d)
            IDLE: begin
                busy_d = 1'b0;
            end
            FINISH: begin
                done_d = 1'b1;
            end
            RD_STROBE: begin
                busy_d = 1'b1;
                rdn_d  = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                busy_d  = 1'b1;
                drive_d = 1'b1;
            end
            WR_STROBE: begin
                busy_d  = 1'b1;
                wrn_d   = 1'b0;
                drive_d = 1'b1;
            end
            default: begin
                busy_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset releases the bus and strobes at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            wdata_q <= 8'h00;
            rdata_q <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdn_q   <= rdn_d;
            wrn_q   <= wrn_d;
            drive_q <= drive_d;
        end
    end

    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rdn       = rdn_q;
    assign wrn       = wrn_q;
    assign uart_data = drive_q ? wdata_q : 8'bzzzzzzzz;

endmodule

// File: tb/tb_uart_bridge.sv
// Self-checking bench for uart_bridge: table of directed transactions, random transactions
// against a latency/result model, and a reset-abort sequence.
`timescale 1ns/1ps
module tb_uart_bridge;

    localparam int RP = 2;
    localparam int WP = 2;
`ifdef UART_BRIDGE_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_read, cmd_write, cmd_status;
    logic [7:0]  wdata;
    wire  [15:0] rdata;
    wire         busy, done, rdn, wrn;
    logic        data_ready, tbre, tsre;
    wire  [7:0]  uart_data;
    logic [7:0]  chip_byte;
    logic [7:0]  probe;
    logic        probe_en;

    // Chip model drives on rdn low; otherwise an optional probe value shows whether the DUT released the bus.
    assign uart_data = (!rdn) ? chip_byte : (probe_en ? probe : 8'bzzzzzzzz);

    uart_bridge #(.RD_PULSE(RP), .WR_PULSE(WP)) dut (
        .CLK(CLK), .RST(RST), .cmd_read(cmd_read), .cmd_write(cmd_write),
        .cmd_status(cmd_status), .wdata(wdata), .rdata(rdata), .busy(busy),
        .done(done), .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
        .rdn(rdn), .wrn(wrn), .uart_data(uart_data)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // kind: 0 status, 1 read, 2 write, 3 all three commands at once
    typedef struct {
        int          kind;
        logic [7:0]  wd;
        logic [7:0]  cb;
        int          dr_at;
        int          tbre_at;
        int          tsre_at;
        bit          drop;
        bit          mid_read;
        int          exp_done;
        logic [15:0] exp_rd;
    } txn_t;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Cycle at which a rising input becomes visible to the sequencer; <=0 means long since high.
    function automatic int eff(input int at);
        return (at <= 0) ? -100 : at + L;
    endfunction

    // Reference: completion cycle, result and strobe windows derived from the protocol rules.
    function automatic void model(input txn_t t, output int dn, output logic [15:0] rd,
                                  output int rf, output int rc, output int wf, output int wc);
        int e, tb, ts;
        logic b1, b0;
        rf = -1; rc = 0; wf = -1; wc = 0;
        if (t.kind >= 2) begin
            wf = 2; wc = WP;
            tb = imax(3 + WP, eff(t.tbre_at));
            ts = imax(tb + 1, eff(t.tsre_at));
            dn = ts + 1;
            rd = 16'h0000;
        end else if (t.kind == 1) begin
            e  = imax(1, eff(t.dr_at));
            rf = e + 1; rc = RP;
            dn = e + RP + 1;
            rd = {8'h00, t.cb};
        end else begin
            b1 = (t.dr_at <= 0);
            b0 = (t.tbre_at <= 0) && (t.tsre_at <= 0);
            dn = 1;
            rd = {14'h0000, b1, b0};
        end
    endfunction

    task automatic set_inputs(input txn_t t, input int c);
        data_ready = (c >= t.dr_at) && !(t.drop && (c > t.dr_at));
        tbre       = (c >= t.tbre_at);
        tsre       = (c >= t.tsre_at);
    endtask

    task automatic run(input txn_t t, input string nm);
        int dn, rf, rc, wf, wc;
        logic [15:0] rd;
        int done_c, done_n, rfirst, rcnt, wfirst, wcnt, bus_err, busy_err, both;
        logic [15:0] got_rd;
        model(t, dn, rd, rf, rc, wf, wc);
        cmd_read = 1'b0; cmd_write = 1'b0; cmd_status = 1'b0;
        probe_en = 1'b1;
        set_inputs(t, 0);
        repeat (3) @(posedge CLK);
        #1;
        done_c = -1; done_n = 0; rfirst = -1; rcnt = 0; wfirst = -1; wcnt = 0;
        bus_err = 0; busy_err = 0; both = 0; got_rd = 16'hxxxx;
        chip_byte = t.cb;
        for (int c = 0; c < 300; c++) begin
            probe_en = !(t.kind >= 2 && c >= 1 && c <= 2 + WP);
            set_inputs(t, c);
            if (c == 0) begin
                wdata      = t.wd;
                cmd_write  = (t.kind >= 2);
                cmd_read   = (t.kind == 1) || (t.kind == 3);
                cmd_status = (t.kind == 0) || (t.kind == 3);
            end else begin
                wdata      = ~t.wd;
                cmd_write  = 1'b0;
                cmd_status = 1'b0;
                cmd_read   = t.mid_read && (c == 3);
            end
            @(negedge CLK);
            if (done) begin
                if (done_c < 0) begin
                    done_c = c;
                    got_rd = rdata;
                end
                done_n++;
            end
            if (!rdn) begin
                if (rfirst < 0) rfirst = c;
                rcnt++;
            end
            if (!wrn) begin
                if (wfirst < 0) wfirst = c;
                wcnt++;
            end
            if (!rdn && !wrn) both++;
            if (busy !== ((c >= 1) && (c < dn))) busy_err++;
            if (probe_en) begin
                if (uart_data !== (rdn ? probe : chip_byte)) bus_err++;
            end else begin
                if (uart_data !== t.wd) bus_err++;
            end
            @(posedge CLK);
            #1;
            if (done_c >= 0 && c >= done_c + 1) break;
        end
        cmd_read = 1'b0;
        check({nm, " done_cycle"}, done_c, t.exp_done);
        check({nm, " done_cycle_model"}, done_c, dn);
        check({nm, " rdata"}, got_rd, t.exp_rd);
        check({nm, " rdata_model"}, got_rd, rd);
        check({nm, " done_width"}, done_n, 1);
        check({nm, " rdn_first"}, rfirst, rf);
        check({nm, " rdn_count"}, rcnt, rc);
        check({nm, " wrn_first"}, wfirst, wf);
        check({nm, " wrn_count"}, wcnt, wc);
        check({nm, " bus_errors"}, bus_err, 0);
        check({nm, " busy_errors"}, busy_err, 0);
        check({nm, " strobes_both_low"}, both, 0);
    endtask

    txn_t tbl[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t r;
        int dn, rf, rc, wf, wc;
        logic [15:0] rd;
        int dcount;

        tbl[0] = '{0, 8'h00, 8'h00, 0,  0,  99, 1'b0, 1'b0, 1,      16'h0002};
        tbl[1] = '{0, 8'h00, 8'h00, 0,  0,  0,  1'b0, 1'b0, 1,      16'h0003};
        tbl[2] = '{0, 8'h00, 8'h00, 99, 99, 99, 1'b0, 1'b0, 1,      16'h0000};
        tbl[3] = '{1, 8'h00, 8'hA5, 5,  0,  0,  1'b0, 1'b0, 8 + L,  16'h00A5};
        tbl[4] = '{1, 8'h00, 8'h5A, 1,  0,  0,  1'b1, 1'b0, 4 + L,  16'h005A};
        tbl[5] = '{2, 8'h3C, 8'hFF, 0,  14, 18, 1'b0, 1'b0, 19 + L, 16'h0000};
        tbl[6] = '{2, 8'hC3, 8'h00, 0,  0,  0,  1'b0, 1'b0, 7,      16'h0000};
        tbl[7] = '{3, 8'h81, 8'h42, 0,  0,  0,  1'b0, 1'b1, 7,      16'h0000};
        tbl[8] = '{2, 8'hE7, 8'h00, 0,  9,  0,  1'b0, 1'b0, 11 + L, 16'h0000};
        tbl[9] = '{0, 8'h00, 8'h00, 99, 0,  0,  1'b0, 1'b0, 1,      16'h0001};

        probe = 8'h96; probe_en = 1'b1; chip_byte = 8'h00;
        cmd_read = 1'b0; cmd_write = 1'b0; cmd_status = 1'b0; wdata = 8'h00;
        data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
        RST = 1'b1;
        #3;
        check("reset rdn", rdn, 1);
        check("reset wrn", wrn, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset rdata", rdata, 16'h0000);
        check("reset bus released", uart_data, probe);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Reset during the write strobe must release wrn and the bus immediately.
        data_ready = 1'b1; tbre = 1'b1; tsre = 1'b1;
        @(posedge CLK); #1;
        wdata = 8'h77; cmd_write = 1'b1;
        @(posedge CLK); #1;
        cmd_write = 1'b0; probe_en = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("abort wrn low before reset", wrn, 0);
        check("abort bus driven before reset", uart_data, 8'h77);
        #2;
        RST = 1'b1; probe_en = 1'b1;
        #1;
        check("abort wrn", wrn, 1);
        check("abort rdn", rdn, 1);
        check("abort bus released", uart_data, probe);
        check("abort busy", busy, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (done) dcount++;
        end
        check("abort no done", dcount, 0);
        run(tbl[1], "status_after_abort");

        for (int i = 0; i < 16; i++) begin
            r.kind     = $urandom_range(0, 3);
            r.wd       = 8'($urandom);
            r.cb       = 8'($urandom);
            r.dr_at    = $urandom_range(0, 6);
            r.tbre_at  = $urandom_range(0, 12);
            r.tsre_at  = $urandom_range(0, 16);
            r.drop     = (r.kind == 1) && (r.dr_at >= 1) && ($urandom_range(0, 1) == 1);
            r.mid_read = (r.kind >= 2) && ($urandom_range(0, 1) == 1);
            model(r, dn, rd, rf, rc, wf, wc);
            r.exp_done = dn;
            r.exp_rd   = rd;
            run(r, $sformatf("rnd%0d_k%0d", i, r.kind));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
